planet_span_sequencer: RTL

- Clocked sequencer that drives the planet span datapath once per scanline from the pixel clock. It replaces edge-on-counter stepping.
- Holds a configurable shape (initial half-span, increment, taper mode) in a shadow register loaded via a valid/ready handshake. The shape is applied at frame boundaries only.
- Outputs per-line span bounds and registered planet RGB to the VGA colour mux.

---
 rtl/planet_span_sequencer_if.sv | 24 ++
 rtl/planet_span_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/planet_span_sequencer_if.sv
// rtl/planet_span_sequencer_if.sv - shape configuration handshake bundle
//
// Purpose: carries one planet shape (half-span, increment, taper mode) from a
// producer to the sequencer's shadow register over a valid/ready handshake.
// Signals:
//   cfg_valid  producer offers a shape
//   cfg_ready  sequencer can take it this cycle
//   cfg_span   initial half-span
//   cfg_inc    initial increment
//   cfg_mode   taper mode (0 linear, 1 quadratic, 2/3 constant)
// Modports: master = shape producer, slave = sequencer.

interface planet_span_sequencer_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [9:0] cfg_span;
   logic [9:0] cfg_inc;
   logic [1:0] cfg_mode;

   modport master (output cfg_valid, output cfg_span, output cfg_inc,
                   output cfg_mode, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_span, input cfg_inc,
                   input cfg_mode, output cfg_ready);
endinterface

// File: rtl/planet_span_sequencer.sv
// rtl/planet_span_sequencer.sv - per-scanline planet span sequencer
//
// Purpose: steps the planet half-span once per scanline (at HCounter==H_LAST)
// through the planet band, and produces registered span bounds and the cyan
// planet pixel for the VGA colour mux. The shape lives in a shadow register
// that is only copied into the working registers at the frame-start trigger.
// Ports:
//   clk, reset_n            pixel clock, synchronous active-low reset
//   HCounter, VCounter      raster position
//   cfg                     shape handshake (slave side)
//   span_left, span_right   registered bounds of the current line
//   span_active             registered: DRAW and VCounter inside the band
//   frame_done              one-cycle pulse after the last band line
//   dR, dG, dB              registered planet colour

module planet_span_sequencer #(
   parameter int PLANET_TOP    = 456,
   parameter int PLANET_BOTTOM = 515,
   parameter int CENTER_X      = 464,
   parameter int H_LAST        = 799,
   parameter int H_VISIBLE     = 640,
   parameter int SPAN_INIT     = 44,
   parameter int INC_INIT      = 33
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [9:0]             HCounter,
   input  logic [9:0]             VCounter,
   planet_span_sequencer_if.slave cfg,
   output logic [9:0]             span_left,
   output logic [9:0]             span_right,
   output logic                   span_active,
   output logic                   frame_done,
   output logic                   dR,
   output logic                   dG,
   output logic                   dB
);

   localparam logic [9:0]  TOP_V  = 10'(PLANET_TOP);
   localparam logic [9:0]  TRIG_V = 10'(PLANET_TOP - 1);
   localparam logic [9:0]  BOT_V  = 10'(PLANET_BOTTOM);
   localparam logic [9:0]  CX     = 10'(CENTER_X);
   localparam logic [9:0]  HL     = 10'(H_LAST);
   localparam logic [9:0]  HV     = 10'(H_VISIBLE);
   localparam logic [10:0] HV_MAX = 11'(H_VISIBLE - 1);

   typedef enum logic {IDLE, DRAW} state_t;

   state_t      state, state_nxt;
   logic [9:0]  sh_span, sh_inc;
   logic [1:0]  sh_mode;
   logic [9:0]  span, inc, diff;

   logic        at_step, in_band, trigger;
   logic        load, step_en, done_c, pix_on, act_c;
   logic [10:0] span_sum, right_sum;
   logic [9:0]  span_step, inc_step, left_c, right_c;

   assign at_step = (HCounter == HL);
   assign in_band = (VCounter >= TOP_V) && (VCounter <= BOT_V);
   assign trigger = at_step && (VCounter == TRIG_V);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the band can only be entered through the trigger line,
   // so a reset or power-up inside the band idles until the next frame.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (trigger)                         state_nxt = DRAW;
         DRAW: if (at_step && (VCounter == BOT_V)) state_nxt = IDLE;
         default:                                   state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      load          = (state == IDLE) && trigger;
      step_en       = (state == DRAW) && at_step && (VCounter < BOT_V);
      done_c        = (state == DRAW) && at_step && (VCounter == BOT_V);
      act_c         = (state == DRAW) && in_band;
      // Ready already drops on the trigger line, so a load never races a config write.
      cfg.cfg_ready = reset_n && (state == IDLE) &&
                      !((VCounter >= TRIG_V) && (VCounter <= BOT_V));
      pix_on        = act_c && (HCounter < HV) &&
                      (HCounter >= left_c) && (HCounter <= right_c);
   end

   // Shape step arithmetic, all from the old register values
   always_comb begin
      span_sum  = {1'b0, span} + {1'b0, inc};
      span_step = span_sum[10] ? 10'h3FF : span_sum[9:0];
      case (sh_mode)
         2'd0:    inc_step = (inc == 10'd0) ? 10'd0 : inc - 10'd1;
         2'd1:    inc_step = (inc < diff)   ? 10'd0 : inc - diff;
         default: inc_step = inc;
      endcase
   end

   // Bounds, clamped to the left screen edge and the last visible pixel
   always_comb begin
      left_c    = (span > CX) ? 10'd0 : CX - span;
      right_sum = {1'b0, CX} + {1'b0, span};
      right_c   = (right_sum > HV_MAX) ? HV_MAX[9:0] : right_sum[9:0];
   end

   // Shadow and working shape registers. The shadow can only be written while
   // IDLE outside the band, so reading sh_mode during DRAW is frame-stable.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_span <= 10'(SPAN_INIT);
         sh_inc  <= 10'(INC_INIT);
         sh_mode <= 2'd0;
         span    <= 10'd0;
         inc     <= 10'd0;
         diff    <= 10'd0;
      end else begin
         if (cfg.cfg_valid && cfg.cfg_ready) begin
            sh_span <= cfg.cfg_span;
            sh_inc  <= cfg.cfg_inc;
            sh_mode <= cfg.cfg_mode;
         end
         if (load) begin
            span <= sh_span;
            inc  <= sh_inc;
            diff <= 10'd0;
         end else if (step_en) begin
            span <= span_step;
            inc  <= inc_step;
            if ((sh_mode == 2'd1) && (diff != 10'h3FF)) diff <= diff + 10'd1;
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         span_left   <= 10'd0;
         span_right  <= 10'd0;
         span_active <= 1'b0;
         frame_done  <= 1'b0;
         dR          <= 1'b0;
         dG          <= 1'b0;
         dB          <= 1'b0;
      end else begin
         span_left   <= left_c;
         span_right  <= right_c;
         span_active <= act_c;
         frame_done  <= done_c;
         dR          <= 1'b0;
         dG          <= pix_on;
         dB          <= pix_on;
      end
   end

endmodule
